// File: rtl/spu_imm_load_pipe.sv
// Immediate-load execution unit for the SPU even pipe (ILH/ILHU/IL/ILA/IOHL).
// The result is formed combinationally at issue, then carried through NUM_PIPES elastic stages.
module spu_imm_load_pipe #(
   parameter int NUM_PIPES = 2,
   parameter int DATA_W    = 128,
   parameter int ADDR_W    = 7,
   parameter int IMM_W     = 18
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [10:0]       in_op,
   input  logic [IMM_W-1:0]  in_imm,
   input  logic [ADDR_W-1:0] in_rt,
   input  logic [DATA_W-1:0] in_rt_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_rt,
   output logic [DATA_W-1:0] out_data,
   output logic              out_illegal,
   output logic              busy
);

   localparam int NUM_WORDS = DATA_W / 32;

   localparam logic [10:0] OP_ILH  = 11'b00010000011;
   localparam logic [10:0] OP_ILHU = 11'b00010000010;
   localparam logic [10:0] OP_IL   = 11'b00010000001;
   localparam logic [10:0] OP_ILA  = 11'b00000100001;
   localparam logic [10:0] OP_IOHL = 11'b00011000001;

   function automatic logic op_illegal(input logic [10:0] op);
      case (op)
         OP_ILH, OP_ILHU, OP_IL, OP_ILA, OP_IOHL: op_illegal = 1'b0;
         default:                                 op_illegal = 1'b1;
      endcase
   endfunction

   // Unrecognised opcodes produce a zero word so out_data is zero for illegal ops.
   function automatic logic [31:0] word_result(input logic [10:0]      op,
                                               input logic [IMM_W-1:0] imm,
                                               input logic [31:0]      rt_word);
      logic signed [15:0] i16;
      i16 = imm[15:0];
      case (op)
         OP_ILH:  word_result = {i16, i16};
         OP_ILHU: word_result = {i16, 16'h0000};
         OP_IL:   word_result = 32'(i16);
         OP_ILA:  word_result = {{(32-18){1'b0}}, imm[17:0]};
         OP_IOHL: word_result = rt_word | {16'h0000, i16};
         default: word_result = 32'h0000_0000;
      endcase
   endfunction

   logic [DATA_W-1:0]    res_data;
   logic                 res_ill;

   logic [NUM_PIPES-1:0] vld_p;
   logic [NUM_PIPES-1:0] ill_p;
   logic [NUM_PIPES-1:0] adv;
   logic [ADDR_W-1:0]    rt_p   [NUM_PIPES];
   logic [DATA_W-1:0]    data_p [NUM_PIPES];

   always_comb begin
      res_data = '0;
      for (int w = 0; w < NUM_WORDS; w++) begin
         res_data[32*w +: 32] = word_result(in_op, in_imm, in_rt_data[32*w +: 32]);
      end
      res_ill = op_illegal(in_op);
   end

   // Advance chain runs from the output back to stage 0 so empty stages absorb stalls.
   always_comb begin : adv_chain
      logic chain;
      adv   = '0;
      chain = ~vld_p[NUM_PIPES-1] | out_ready;
      adv[NUM_PIPES-1] = chain;
      for (int k = NUM_PIPES - 2; k >= 0; k--) begin
         chain  = ~vld_p[k] | chain;
         adv[k] = chain;
      end
   end

   // Stage 0 captures the issued op; stages 1..NUM_PIPES-1 shift it towards the output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p <= '0;
         ill_p <= '0;
         for (int k = 0; k < NUM_PIPES; k++) begin
            rt_p[k]   <= '0;
            data_p[k] <= '0;
         end
      end else if (flush) begin
         vld_p <= '0;
      end else begin
         if (adv[0]) begin
            vld_p[0] <= in_valid;
            if (in_valid) begin
               rt_p[0]   <= in_rt;
               data_p[0] <= res_data;
               ill_p[0]  <= res_ill;
            end
         end
         for (int k = 1; k < NUM_PIPES; k++) begin
            if (adv[k]) begin
               vld_p[k] <= vld_p[k-1];
               if (vld_p[k-1]) begin
                  rt_p[k]   <= rt_p[k-1];
                  data_p[k] <= data_p[k-1];
                  ill_p[k]  <= ill_p[k-1];
               end
            end
         end
      end
   end

   assign in_ready    = adv[0];
   assign out_valid   = vld_p[NUM_PIPES-1];
   assign out_rt      = rt_p[NUM_PIPES-1];
   assign out_data    = data_p[NUM_PIPES-1];
   assign out_illegal = ill_p[NUM_PIPES-1];
   assign busy        = |vld_p;

endmodule

// File: tb/tb_spu_imm_load_pipe.sv
// Scoreboard bench for spu_imm_load_pipe at depths 2, 1 and 8 against an opcode-level reference model.
module tb_spu_imm_load_pipe;

   localparam int ND = 3;
   localparam int DW = 128;
   localparam int AW = 7;
   localparam int IW = 18;

   localparam logic [10:0] ILH  = 11'b00010000011;
   localparam logic [10:0] ILHU = 11'b00010000010;
   localparam logic [10:0] IL   = 11'b00010000001;
   localparam logic [10:0] ILA  = 11'b00000100001;
   localparam logic [10:0] IOHL = 11'b00011000001;

   function automatic int pp(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 8);
   endfunction

   typedef struct {
      logic [AW-1:0] rt;
      logic [DW-1:0] data;
      logic          ill;
      int            acc;
      bit            lat;
      bit            seen;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;
   logic          in_valid    [ND];
   logic          in_ready    [ND];
   logic [10:0]   in_op       [ND];
   logic [IW-1:0] in_imm      [ND];
   logic [AW-1:0] in_rt       [ND];
   logic [DW-1:0] in_rt_data  [ND];
   logic          out_valid   [ND];
   logic          out_ready   [ND];
   logic [AW-1:0] out_rt      [ND];
   logic [DW-1:0] out_data    [ND];
   logic          out_illegal [ND];
   logic          busy        [ND];
   bit            rmode       [ND];

   exp_t exp_q [ND][$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", n, act, exp);
      end
   endfunction

   // Reference: each 32-bit word computed from the opcode rule with integer arithmetic.
   function automatic logic [DW-1:0] ref_res(input logic [10:0] op, input logic [IW-1:0] imm,
                                             input logic [DW-1:0] rtd, output logic ill);
      int unsigned i16, w32;
      int s;
      logic [DW-1:0] r;
      r   = '0;
      ill = 1'b0;
      i16 = 32'(imm) % 65536;
      for (int w = 0; w < DW/32; w++) begin
         case (op)
            ILH:  w32 = i16 * 65536 + i16;
            ILHU: w32 = i16 * 65536;
            IL:   begin s = (i16 >= 32768) ? int'(i16) - 65536 : int'(i16); w32 = 32'(s); end
            ILA:  w32 = 32'(imm);
            IOHL: w32 = rtd[32*w +: 32] | i16;
            default: begin w32 = 0; ill = 1'b1; end
         endcase
         r[32*w +: 32] = w32;
      end
      return r;
   endfunction

   task automatic monitor(input int g);
      exp_t e;
      if (out_valid[g]) begin
         if (exp_q[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_d%0d actual rt=%0d data=%h required none", g, out_rt[g], out_data[g]);
         end else begin
            e = exp_q[g][0];
            chk($sformatf("rt_d%0d", g), DW'(out_rt[g]), DW'(e.rt));
            chk($sformatf("data_d%0d", g), out_data[g], e.data);
            chk($sformatf("illegal_d%0d", g), DW'(out_illegal[g]), DW'(e.ill));
            if (e.lat && !e.seen) chk($sformatf("latency_d%0d", g), DW'(cyc - e.acc), DW'(pp(g)));
            e.seen = 1'b1;
            exp_q[g][0] = e;
            if (out_ready[g]) void'(exp_q[g].pop_front());
         end
      end
   endtask

   generate
      for (genvar g = 0; g < ND; g++) begin : gd
         spu_imm_load_pipe #(.NUM_PIPES(pp(g)), .DATA_W(DW), .ADDR_W(AW), .IMM_W(IW)) dut (
            .clk(clk), .rst_n(rst_n), .flush(flush),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_op(in_op[g]),
            .in_imm(in_imm[g]), .in_rt(in_rt[g]), .in_rt_data(in_rt_data[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_rt(out_rt[g]),
            .out_data(out_data[g]), .out_illegal(out_illegal[g]), .busy(busy[g])
         );
         initial forever begin
            @(negedge clk);
            if (rmode[g]) out_ready[g] = 1'($urandom_range(0, 1));
         end
         initial forever begin
            @(negedge clk);
            #4;
            if (rst_n) monitor(g);
         end
      end
   endgenerate

   task automatic present(input int d, input logic [10:0] op, input logic [IW-1:0] imm,
                          input logic [AW-1:0] rt, input logic [DW-1:0] rtd);
      in_valid[d] = 1'b1; in_op[d] = op; in_imm[d] = imm; in_rt[d] = rt; in_rt_data[d] = rtd;
   endtask

   task automatic issue(input int d, input logic [10:0] op, input logic [IW-1:0] imm,
                        input logic [DW-1:0] rtd, input bit lat);
      exp_t e;
      logic ill;
      bit done = 1'b0;
      e.rt   = AW'($urandom);
      e.data = ref_res(op, imm, rtd, ill);
      e.ill  = ill;
      e.lat  = lat;
      e.seen = 1'b0;
      for (int t = 0; t < 300 && !done; t++) begin
         @(negedge clk);
         present(d, op, imm, e.rt, rtd);
         #4;
         if (in_ready[d] && !flush) begin
            e.acc = cyc;
            exp_q[d].push_back(e);
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout_d%0d actual in_ready=0 required acceptance", d);
      end
   endtask

   task automatic idle(input int d, input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid[d] = 1'b0;
      end
   endtask

   task automatic drain(input int d);
      int t = 0;
      while ((exp_q[d].size() != 0 || busy[d]) && t < 500) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk($sformatf("drain_d%0d", d), DW'(exp_q[d].size()), DW'(0));
   endtask

   function automatic logic [10:0] rand_op();
      case ($urandom_range(0, 5))
         0: return ILH;
         1: return ILHU;
         2: return IL;
         3: return ILA;
         4: return IOHL;
         default: return 11'($urandom);
      endcase
   endfunction

   function automatic logic [DW-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic rand_burst(input int d, input int n, input bit lat);
      for (int i = 0; i < n; i++) begin
         issue(d, rand_op(), IW'($urandom), rand_data(), lat);
         if ($urandom_range(0, 2) == 0) idle(d, $urandom_range(1, 2));
      end
      idle(d, 1);
   endtask

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] rt2;
      rst_n = 1'b0;
      flush = 1'b0;
      for (int g = 0; g < ND; g++) begin
         in_valid[g] = 1'b0; in_op[g] = '0; in_imm[g] = '0; in_rt[g] = '0;
         in_rt_data[g] = '0; out_ready[g] = 1'b1; rmode[g] = 1'b0;
      end
      #3;
      for (int g = 0; g < ND; g++) begin
         chk($sformatf("rst_out_valid_d%0d", g), DW'(out_valid[g]), DW'(0));
         chk($sformatf("rst_busy_d%0d", g), DW'(busy[g]), DW'(0));
         chk($sformatf("rst_in_ready_d%0d", g), DW'(in_ready[g]), DW'(1));
         chk($sformatf("rst_out_data_d%0d", g), out_data[g], DW'(0));
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed opcode cases, back to back with out_ready high.
      issue(0, ILH, 18'h0ABCD, rand_data(), 1'b1);
      issue(0, ILHU, 18'h31234, rand_data(), 1'b1);
      issue(0, IL, 18'h08001, rand_data(), 1'b1);
      issue(0, ILA, 18'h3FFFF, rand_data(), 1'b1);
      issue(0, IOHL, 18'h05678, {4{32'h12340000}}, 1'b1);
      issue(0, 11'h7FF, IW'($urandom), rand_data(), 1'b1);
      idle(0, 1);
      drain(0);
      rand_burst(0, 40, 1'b1);
      drain(0);

      // Random backpressure on the depth-2 unit.
      @(negedge clk);
      rmode[0] = 1'b1;
      rand_burst(0, 100, 1'b0);
      @(negedge clk);
      rmode[0] = 1'b0;
      out_ready[0] = 1'b1;
      drain(0);

      // Stall: two ops fill the pipe, a third is refused until out_ready rises.
      @(negedge clk);
      out_ready[0] = 1'b0;
      issue(0, ILH, 18'h01111, rand_data(), 1'b0);
      issue(0, IL, 18'h0F00F, rand_data(), 1'b0);
      rt2 = AW'($urandom);
      @(negedge clk);
      present(0, ILHU, 18'h02222, rt2, rand_data());
      #4;
      chk("bp_in_ready", DW'(in_ready[0]), DW'(0));
      repeat (3) begin
         @(negedge clk);
         #4;
         chk("bp_in_ready_hold", DW'(in_ready[0]), DW'(0));
      end
      @(negedge clk);
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b1;
      #4;
      chk("bp_ready_from_out_ready", DW'(in_ready[0]), DW'(1));
      issue(0, ILHU, 18'h02222, rand_data(), 1'b0);
      issue(0, IOHL, 18'h00FF0, rand_data(), 1'b0);
      idle(0, 1);
      drain(0);

      // Flush with two ops in flight and a third presented.
      @(negedge clk);
      out_ready[0] = 1'b0;
      issue(0, ILA, 18'h12345, rand_data(), 1'b0);
      issue(0, ILH, 18'h0BEEF, rand_data(), 1'b0);
      @(negedge clk);
      present(0, IL, 18'h07777, AW'($urandom), rand_data());
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      in_valid[0] = 1'b0;
      exp_q[0].delete();
      #4;
      chk("flush_out_valid", DW'(out_valid[0]), DW'(0));
      chk("flush_busy", DW'(busy[0]), DW'(0));
      @(negedge clk);
      out_ready[0] = 1'b1;
      idle(0, 12);
      drain(0);

      // Asynchronous reset in the middle of a stalled stream.
      @(negedge clk);
      out_ready[0] = 1'b0;
      issue(0, ILH, 18'h0ABCD, rand_data(), 1'b0);
      issue(0, ILHU, 18'h0ABCD, rand_data(), 1'b0);
      @(negedge clk);
      in_valid[0] = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", DW'(out_valid[0]), DW'(0));
      chk("arst_out_data", out_data[0], DW'(0));
      chk("arst_out_rt", DW'(out_rt[0]), DW'(0));
      chk("arst_out_illegal", DW'(out_illegal[0]), DW'(0));
      chk("arst_busy", DW'(busy[0]), DW'(0));
      chk("arst_in_ready", DW'(in_ready[0]), DW'(1));
      for (int g = 0; g < ND; g++) exp_q[g].delete();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready[0] = 1'b1;
      rand_burst(0, 10, 1'b1);
      drain(0);

      // Depth sweep: random stream with random out_ready, then latency with out_ready held high.
      for (int d = 1; d < ND; d++) begin
         @(negedge clk);
         rmode[d] = 1'b1;
         rand_burst(d, 150, 1'b0);
         @(negedge clk);
         rmode[d] = 1'b0;
         out_ready[d] = 1'b1;
         drain(d);
         rand_burst(d, 30, 1'b1);
         drain(d);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
